move_replay: RTL and testbench
==============================

# move_replay

Downstream consumer of the solver register file. When the solver raises `comp`, this block captures the solution depth (`cnt`) and the packed move list (`ord`), then replays the moves one at a time on the 2x3 starting board. It streams each intermediate board over a valid/ready handshake to the display/UART stage, and at the end reports whether the final board equals the goal board. It independently checks the solver output and never writes back into the register file.

## Interface
Parameters:
- MAX_DEPTH, 20, maximum legal move count (ord holds 20 two-bit moves)

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- comp  in  1  solver-complete level from register file; rising edge starts a replay
- cnt  in  26  solution depth; only cnt[4:0] is used, cnt[25:5] ignored
- ord  in  44  packed moves; step k (1..20) at ord[2k-1:2k-2]; ord[43:40] ignored
- start_board  in  18  initial board; cell i at bits [3i+2:3i], i = row*3+col, tile 000 = blank
- goal_board  in  18  goal board, same encoding
- out_valid  out  1  board beat valid
- out_ready  in  1  downstream accepts beat
- out_board  out  18  board after out_step moves
- out_step  out  5  step index of beat (0 = initial board)
- out_move  out  2  move applied to reach this board (00 on step 0)
- out_last  out  1  final beat of the replay
- busy  out  1  replay in progress
- done  out  1  one-cycle pulse at replay end
- match  out  1  final board == goal_board; valid from done, held until next start
- err  out  1  replay aborted (illegal move, depth > MAX_DEPTH, or no blank); held until next start

## Operation
- Move codes move the blank: 00 up (b-3), 01 right (b+1), 10 down (b+3), 11 left (b-1). Legal only if b>=3 / b%3!=2 / b<3 / b%3!=0 respectively. The tile at the target cell is swapped into the old blank cell.
- Start detection: comp registered as comp_q. Start = comp & ~comp_q & state==IDLE. Edges seen while not IDLE are ignored. comp held high after done does not restart the replay.
- FSM states: IDLE, EMIT, ADVANCE, FINISH.
  - IDLE: on start, latch depth = cnt[4:0], moves = ord[39:0], board = start_board, step = 0, and clear err/match. If depth > MAX_DEPTH, or start_board has no 000 cell, set err and go to FINISH. Otherwise go to EMIT.
  - EMIT: out_valid=1 with the current board, step and move. On out_valid&out_ready: if step==depth go to FINISH, else go to ADVANCE.
  - ADVANCE: take the move for step+1 and locate the blank (lowest-index 000 cell). If the move is legal, apply the swap, increment step, record the move, and go to EMIT. If illegal, set err and go to FINISH; that beat is not emitted.
  - FINISH: done=1 for this single cycle; match = ~err & (board==goal_board). Return to IDLE.
- out_last = (step==depth) while out_valid.
- Beat count for a clean replay is depth+1.

## Timing
- Reset values: out_valid=0, out_board=0, out_step=0, out_move=0, out_last=0, busy=0, done=0, match=0, err=0; FSM in IDLE; comp_q=0.
- Reset is asynchronous and can occur mid-replay. It returns the block to IDLE immediately with all outputs cleared, even mid-beat.
- Start edge sampled at edge N: busy=1 and out_valid=1 (step 0) from edge N+1.
- Each accepted beat costs 2 cycles (EMIT accept, ADVANCE), so the peak rate is 1 beat per 2 cycles.
- The final beat is accepted at edge M. done=1 during cycle M+1 and busy drops at edge M+2. match/err are stable from M+1 until the next start.
- Handshake rules:
  - out_board, out_step, out_move and out_last stay stable while out_valid & ~out_ready.
  - out_valid never drops without acceptance, except on reset.
- Error cases:
  - Depth error: done pulses the cycle after the latch edge, with no beats emitted.
  - Illegal move: done pulses the cycle after ADVANCE.
- Inputs cnt, ord, start_board and goal_board are sampled only at the start edge (goal at FINISH); later changes are ignored.

## Test plan
- start=goal=18'b000_001_010_011_100_101, cnt=0, comp 0->1 -> one beat step0 with out_last=1, then done pulse, match=1, err=0.
- Same boards, cnt=1, ord[1:0]=00 -> beats: step0, then step1 out_board=18'b011_001_010_000_100_101 with out_move=00 and out_last=1; then match=0.
- cnt=2, moves 00 then 10 -> step2 board equals start, so match=1; 3 beats total.
- cnt=1, ord[1:0]=10 (down from blank cell 5) -> only the step0 beat, then err=1, done pulse, match=0.
- cnt=21 -> no beats, err=1, done exactly 2 cycles after the comp rise.
- out_ready low for 5 cycles on step1 -> beat fields stable throughout. rst_n pulsed low mid-replay -> all outputs 0 at once. comp held high afterwards -> no restart until comp toggles low then high.

Source files
------------

// File: rtl/move_replay.sv
// move_replay: replays a captured solver move list on a 2x3 board and streams each board state
module move_replay #(
  parameter int MAX_DEPTH = 20
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        comp,
  input  logic [25:0] cnt,
  input  logic [43:0] ord,
  input  logic [17:0] start_board,
  input  logic [17:0] goal_board,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [17:0] out_board,
  output logic [4:0]  out_step,
  output logic [1:0]  out_move,
  output logic        out_last,
  output logic        busy,
  output logic        done,
  output logic        match,
  output logic        err
);
  typedef enum logic [1:0] {IDLE, EMIT, ADVANCE, FINISH} state_t;
  state_t state;
  logic comp_q, start, legal;
  logic [4:0] depth;
  logic [39:0] moves;
  logic [3:0] fb_start, fb_cur;
  logic [2:0] b, t, t_s;
  logic [1:0] mv;
  logic [17:0] nxt;
  logic unused_bits;
  assign unused_bits = ^{cnt[25:5], ord[43:40]};
  function automatic logic [3:0] find_blank(input logic [17:0] bd);
    logic [3:0] r;
    r = '0;
    for (int i = 5; i >= 0; i--)
      if (bd[3*i +: 3] == 3'd0) r = {1'b1, 3'(i)};
    return r;
  endfunction
  // next move, blank position, legality and the board after the swap
  always_comb begin
    start = comp & ~comp_q & (state == IDLE);
    fb_start = find_blank(start_board);
    fb_cur = find_blank(out_board);
    b = fb_cur[2:0];
    mv = moves[{out_step, 1'b0} +: 2];
    legal = mv == 2'd0 ? b >= 3'd3 : mv == 2'd1 ? (b != 3'd2 && b != 3'd5) :
            mv == 2'd2 ? b < 3'd3 : (b != 3'd0 && b != 3'd3);
    t = mv == 2'd0 ? b - 3'd3 : mv == 2'd1 ? b + 3'd1 : mv == 2'd2 ? b + 3'd3 : b - 3'd1;
    t_s = legal ? t : b;
    nxt = out_board;
    nxt[3*b +: 3] = out_board[3*t_s +: 3];
    nxt[3*t_s +: 3] = 3'd0;
  end
  // replay FSM with registered handshake and status outputs
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      comp_q <= 1'b0;
      depth <= '0;
      moves <= '0;
      out_valid <= 1'b0;
      out_board <= '0;
      out_step <= '0;
      out_move <= '0;
      out_last <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      match <= 1'b0;
      err <= 1'b0;
    end else begin
      comp_q <= comp;
      case (state)
        IDLE: begin
          done <= 1'b0;
          busy <= 1'b0;
          if (start) begin
            depth <= cnt[4:0];
            moves <= ord[39:0];
            out_board <= start_board;
            out_step <= '0;
            out_move <= '0;
            match <= 1'b0;
            busy <= 1'b1;
            if (cnt[4:0] > 5'(MAX_DEPTH) || !fb_start[3]) begin
              err <= 1'b1;
              state <= FINISH;
            end else begin
              err <= 1'b0;
              out_valid <= 1'b1;
              out_last <= cnt[4:0] == 5'd0;
              state <= EMIT;
            end
          end
        end
        EMIT: if (out_ready) begin
          out_valid <= 1'b0;
          out_last <= 1'b0;
          state <= out_step == depth ? FINISH : ADVANCE;
        end
        ADVANCE: if (legal) begin
          out_board <= nxt;
          out_step <= out_step + 5'd1;
          out_move <= mv;
          out_valid <= 1'b1;
          out_last <= out_step + 5'd1 == depth;
          state <= EMIT;
        end else begin
          err <= 1'b1;
          state <= FINISH;
        end
        FINISH: begin
          done <= 1'b1;
          match <= ~err & (out_board == goal_board);
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_move_replay.sv
// tb_move_replay: directed checks of move_replay beats, status, handshake and reset
module tb_move_replay;
  logic clk = 1'b0, rst_n = 1'b0, comp = 1'b0, out_ready = 1'b1;
  logic [25:0] cnt = '0;
  logic [43:0] ord = '0;
  logic [17:0] start_board, goal_board, out_board;
  logic out_valid, out_last, busy, done, match, err;
  logic [4:0] out_step;
  logic [1:0] out_move;
  localparam logic [17:0] S = 18'b000_001_010_011_100_101;
  localparam logic [17:0] A = 18'b011_001_010_000_100_101;
  localparam logic [17:0] B = 18'b001_000_010_011_100_101;
  int n_chk = 0, n_pass = 0, nb, nd;
  logic [17:0] bb[32];
  logic [4:0] bs[32];
  logic [1:0] bm[32];
  logic bl[32];

  move_replay dut (.clk(clk), .rst_n(rst_n), .comp(comp), .cnt(cnt), .ord(ord),
    .start_board(start_board), .goal_board(goal_board), .out_valid(out_valid),
    .out_ready(out_ready), .out_board(out_board), .out_step(out_step), .out_move(out_move),
    .out_last(out_last), .busy(busy), .done(done), .match(match), .err(err));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [17:0] got, input logic [17:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic replay(input logic [4:0] c, input logic [43:0] o);
    @(negedge clk);
    comp = 1'b0;
    cnt = {21'h0A5A5, c};
    ord = o;
    @(negedge clk);
    comp = 1'b1;
    nb = 0;
    nd = 0;
    for (int i = 0; i < 200 && !(nd > 0 && !busy); i++) begin
      @(negedge clk);
      if (done) nd++;
      if (out_valid && out_ready && nb < 32) begin
        bb[nb] = out_board;
        bs[nb] = out_step;
        bm[nb] = out_move;
        bl[nb] = out_last;
        nb++;
      end
    end
    check("done_pulses", 18'(nd), 18'd1);
  endtask

  initial begin
    start_board = S;
    goal_board = S;
    #1;
    check("rst_valid", 18'(out_valid), 18'd0);
    check("rst_board", out_board, 18'd0);
    check("rst_busy", 18'(busy), 18'd0);
    check("rst_status", 18'({done, match, err, out_last}), 18'd0);
    @(negedge clk);
    rst_n = 1'b1;

    replay(5'd0, 44'd0);
    check("t1_beats", 18'(nb), 18'd1);
    check("t1_b0", bb[0], S);
    check("t1_s0", 18'({bs[0], bm[0], bl[0]}), 18'b00000_00_1);
    check("t1_match", 18'(match), 18'd1);
    check("t1_err", 18'(err), 18'd0);
    repeat (4) @(negedge clk);
    check("hold_high_no_restart", 18'({busy, out_valid}), 18'd0);

    replay(5'd1, 44'd0);
    check("t2_beats", 18'(nb), 18'd2);
    check("t2_last0", 18'(bl[0]), 18'd0);
    check("t2_b1", bb[1], A);
    check("t2_s1", 18'({bs[1], bm[1], bl[1]}), 18'b00001_00_1);
    check("t2_match", 18'({match, err}), 18'b00);

    replay(5'd2, 44'hF0000000008);
    check("t3_beats", 18'(nb), 18'd3);
    check("t3_b1", bb[1], A);
    check("t3_b2", bb[2], S);
    check("t3_s2", 18'({bs[2], bm[2], bl[2]}), 18'b00010_10_1);
    check("t3_match", 18'({match, err}), 18'b10);

    replay(5'd2, 44'h7);
    check("t8_beats", 18'(nb), 18'd3);
    check("t8_b1", bb[1], B);
    check("t8_m", 18'({bm[1], bm[2]}), 18'b11_01);
    check("t8_b2", bb[2], S);
    check("t8_match", 18'(match), 18'd1);

    replay(5'd1, 44'h2);
    check("t4_beats", 18'(nb), 18'd1);
    check("t4_err", 18'({match, err}), 18'b01);

    @(negedge clk);
    comp = 1'b0;
    cnt = 26'd21;
    @(negedge clk);
    comp = 1'b1;
    @(negedge clk);
    check("dep_c1", 18'({done, busy, out_valid}), 18'b010);
    @(negedge clk);
    check("dep_c2", 18'({done, out_valid, err}), 18'b101);
    @(negedge clk);
    check("dep_c3", 18'({done, busy, err, match}), 18'b0010);

    out_ready = 1'b0;
    @(negedge clk);
    comp = 1'b0;
    cnt = 26'd1;
    ord = 44'd0;
    @(negedge clk);
    comp = 1'b1;
    @(negedge clk);
    check("st_beat0", 18'({out_valid, out_step}), 18'b1_00000);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("st_adv", 18'(out_valid), 18'd0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("st_board", out_board, A);
      check("st_fields", 18'({out_valid, out_step, out_move, out_last}), 18'b1_00001_00_1);
    end
    #2;
    rst_n = 1'b0;
    comp = 1'b0;
    #1;
    check("mid_rst_valid", 18'({out_valid, busy, out_last}), 18'd0);
    check("mid_rst_board", out_board, 18'd0);
    check("mid_rst_step", 18'({out_step, out_move, err, match, done}), 18'd0);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;

    replay(5'd1, 44'd0);
    check("post_rst_beats", 18'(nb), 18'd2);
    check("post_rst_b1", bb[1], A);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
